bram_fifo_ctrl: RTL and testbench



---
 rtl/bram_fifo_ctrl_if.sv | 31 +++
 rtl/bram_fifo_ctrl.sv | 88 ++++++++
 tb/tb_bram_fifo_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/bram_fifo_ctrl_if.sv
// Streaming and RAM-port signals of bram_fifo_ctrl.
// The slave modport is the controller's view; master is the environment's view.
interface bram_fifo_ctrl_if #(
    parameter int DBITS = 16,
    parameter int ABITS = 9
);
    logic [DBITS-1:0] IN_DAT;
    logic             IN_VLD;
    logic             IN_RDY;
    logic [DBITS-1:0] OUT_DAT;
    logic             OUT_VLD;
    logic             OUT_RDY;
    logic [ABITS+1:0] COUNT;
    logic             FULL;
    logic             EMPTY;
    logic [ABITS-1:0] WADR;
    logic [DBITS-1:0] WDAT;
    logic             WEN;
    logic [ABITS-1:0] RADR;
    logic [DBITS-1:0] RDAT;

    modport slave (
        input  IN_DAT, IN_VLD, OUT_RDY, RDAT,
        output IN_RDY, OUT_DAT, OUT_VLD, COUNT, FULL, EMPTY, WADR, WDAT, WEN, RADR
    );

    modport master (
        output IN_DAT, IN_VLD, OUT_RDY, RDAT,
        input  IN_RDY, OUT_DAT, OUT_VLD, COUNT, FULL, EMPTY, WADR, WDAT, WEN, RADR
    );
endinterface

// File: rtl/bram_fifo_ctrl.sv
// Valid/ready FIFO controller around an external simple dual-port RAM with 1-cycle
// registered read; a 2-entry skid buffer absorbs the read latency for full-rate streaming.
module bram_fifo_ctrl #(
    parameter int DBITS = 16,
    parameter int ABITS = 9
) (
    input logic             CLK,
    input logic             RSTN,
    bram_fifo_ctrl_if.slave bus
);
    localparam logic [ABITS:0] DEPTH = {1'b1, {ABITS{1'b0}}};

    logic [ABITS-1:0] wptr_q, wptr_d;
    logic [ABITS-1:0] rptr_q, rptr_d;
    logic [ABITS:0]   cnt_q, cnt_d;
    logic             infl_q, infl_d;
    logic [1:0]       sk_q, sk_d;
    logic [DBITS-1:0] sk0_q, sk0_d;
    logic [DBITS-1:0] sk1_q, sk1_d;

    logic             in_rdy;
    logic             push;
    logic             pop;
    logic             rd;
    logic [1:0]       occ;
    logic [ABITS+1:0] count;

    always_comb begin
        in_rdy = RSTN & (cnt_q != DEPTH);
        push   = bus.IN_VLD & in_rdy;
        pop    = (sk_q != 2'd0) & bus.OUT_RDY;
        occ    = sk_q + {1'b0, infl_q};
        // A pop frees a skid slot this cycle, so a read may be issued even at occupancy 2.
        rd     = (cnt_q != '0) & ((occ < 2'd2) | pop);

        wptr_d = wptr_q + ABITS'(push);
        rptr_d = rptr_q + ABITS'(rd);
        cnt_d  = cnt_q + (ABITS+1)'(push) - (ABITS+1)'(rd);
        infl_d = rd;
        sk_d   = sk_q + {1'b0, infl_q} - {1'b0, pop};

        sk0_d = sk0_q;
        sk1_d = sk1_q;
        if (pop) begin
            sk0_d = sk1_q;
            if (infl_q) begin
                if (sk_q == 2'd1) sk0_d = bus.RDAT;
                else              sk1_d = bus.RDAT;
            end
        end else if (infl_q) begin
            if (sk_q == 2'd0) sk0_d = bus.RDAT;
            else              sk1_d = bus.RDAT;
        end

        count = {1'b0, cnt_q} + (ABITS+2)'(infl_q) + (ABITS+2)'(sk_q);
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            infl_q <= 1'b0;
            sk_q   <= 2'd0;
            sk0_q  <= '0;
            sk1_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            infl_q <= infl_d;
            sk_q   <= sk_d;
            sk0_q  <= sk0_d;
            sk1_q  <= sk1_d;
        end
    end

    assign bus.IN_RDY  = in_rdy;
    assign bus.OUT_DAT = sk0_q;
    assign bus.OUT_VLD = (sk_q != 2'd0);
    assign bus.COUNT   = count;
    assign bus.FULL    = (cnt_q == DEPTH);
    assign bus.EMPTY   = (count == '0);
    assign bus.WADR    = wptr_q;
    assign bus.WDAT    = bus.IN_DAT;
    assign bus.WEN     = push;
    assign bus.RADR    = rptr_q;
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Scoreboard bench for bram_fifo_ctrl with a behavioural old-data dual-port RAM attached.
module tb_bram_fifo_ctrl;
    localparam int DBITS = 16;
    localparam int ABITS = 9;
    localparam int DEPTH = 1 << ABITS;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    bram_fifo_ctrl_if #(.DBITS(DBITS), .ABITS(ABITS)) bus ();

    bram_fifo_ctrl #(.DBITS(DBITS), .ABITS(ABITS)) dut (
        .CLK (CLK),
        .RSTN(RSTN),
        .bus (bus)
    );

    logic [DBITS-1:0] mem [0:DEPTH-1];
    always @(posedge CLK) begin
        if (bus.WEN) mem[bus.WADR] <= bus.WDAT;
        bus.RDAT <= mem[bus.RADR];
    end

    logic [DBITS-1:0] sb[$];
    int n_chk = 0;
    int n_fail = 0;
    int npush = 0;
    int npop = 0;
    logic [DBITS-1:0] last_pop = '0;
    bit rst_edge = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, observe 1ns later, account the
    // handshakes that the next rising edge will complete.
    task automatic cycle(input logic vld, input logic [DBITS-1:0] dat, input logic ordy,
                         input logic rstn);
        logic [DBITS-1:0] exp;
        @(negedge CLK);
        RSTN = rstn;
        bus.IN_VLD = vld;
        bus.IN_DAT = dat;
        bus.OUT_RDY = ordy;
        #1;
        if (!rstn) begin
            check("rst_in_rdy", bus.IN_RDY, 0);
            check("rst_wen", bus.WEN, 0);
            if (rst_edge) begin
                check("rst_out_vld", bus.OUT_VLD, 0);
                check("rst_out_dat", bus.OUT_DAT, 0);
                check("rst_count", bus.COUNT, 0);
                check("rst_empty", bus.EMPTY, 1);
            end
            sb.delete();
            rst_edge = 1'b1;
        end else begin
            check("count", bus.COUNT, 32'(sb.size()));
            check("empty", bus.EMPTY, 32'(sb.size() == 0));
            check("full", bus.FULL, !bus.IN_RDY);
            check("wen", bus.WEN, vld & bus.IN_RDY);
            check("skid_occ", 32'((dut.sk_q + 3'(dut.infl_q)) <= 3'd2), 1);
            if (bus.OUT_VLD && ordy) begin
                if (sb.size() == 0) begin
                    check("pop_underflow", 1, 0);
                end else begin
                    exp = sb.pop_front();
                    check("data", bus.OUT_DAT, exp);
                end
                last_pop = bus.OUT_DAT;
                npop++;
            end
            if (vld && bus.IN_RDY) begin
                sb.push_back(dat);
                npush++;
            end
            rst_edge = 1'b0;
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((sb.size() != 0 || bus.COUNT != 0) && k < budget) begin
            cycle(1'b0, '0, 1'b1, 1'b1);
            k++;
        end
        check("drain_done", 32'(sb.size()), 0);
    endtask

    initial begin
        int base;
        int k;
        bus.IN_VLD = 1'b0;
        bus.IN_DAT = '0;
        bus.OUT_RDY = 1'b0;

        // Reset
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'hdead, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("post_rst_in_rdy", bus.IN_RDY, 1);

        // Single word latency
        cycle(1'b1, 16'hA5A5, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        check("lat_after_e0", bus.OUT_VLD, 0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        check("lat_after_e1", bus.OUT_VLD, 0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        check("lat_after_e2_vld", bus.OUT_VLD, 1);
        check("lat_after_e2_dat", bus.OUT_DAT, 16'hA5A5);
        cycle(1'b0, '0, 1'b1, 1'b1);
        check("single_count", bus.COUNT, 0);
        check("single_empty", bus.EMPTY, 1);

        // Fill with OUT_RDY low
        base = npush;
        k = 0;
        while (npush - base < DEPTH + 2 && k < 2000) begin
            cycle(1'b1, DBITS'(npush - base), 1'b0, 1'b1);
            k++;
        end
        check("fill_accepts", 32'(npush - base), DEPTH + 2);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 16'hffff, 1'b0, 1'b1);
            check("fill_in_rdy", bus.IN_RDY, 0);
            check("fill_full", bus.FULL, 1);
            check("fill_count", bus.COUNT, DEPTH + 2);
        end
        cycle(1'b0, '0, 1'b1, 1'b1);
        check("fill_first_pop", last_pop, 0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("fill_in_rdy_back", bus.IN_RDY, 1);
        base = npop;
        drain(2000);
        check("fill_pops", 32'(npop - base + 1), DEPTH + 2);
        check("fill_last", last_pop, DEPTH + 1);

        // Streaming
        for (int i = 0; i < 2000; i++) begin
            cycle(1'b1, DBITS'(16'h4000 + i), 1'b1, 1'b1);
            if (i >= 3) begin
                check("stream_vld", bus.OUT_VLD, 1);
                check("stream_count", bus.COUNT, 3);
            end
        end
        drain(20);

        // Wrap-around with moderate backpressure
        base = npush;
        k = 0;
        while (npush - base < 1500 && k < 10000) begin
            cycle(1'b1, DBITS'(16'h8000 + npush - base), 1'((k % 3) != 0), 1'b1);
            k++;
        end
        check("wrap_accepts", 32'(npush - base), 1500);
        drain(1000);

        // Random valid and backpressure
        base = npush;
        k = 0;
        while (npush - base < 5000 && k < 40000) begin
            cycle(1'($urandom_range(0, 1)), DBITS'($urandom), 1'($urandom_range(0, 2) != 0), 1'b1);
            k++;
        end
        check("rand_accepts", 32'(npush - base), 5000);
        drain(1000);

        // Reset mid-burst at COUNT=37
        k = 0;
        while (sb.size() < 37 && k < 100) begin
            cycle(1'b1, DBITS'(16'hc000 + k), 1'b0, 1'b1);
            k++;
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("burst_count", bus.COUNT, 37);
        cycle(1'b1, 16'hbeef, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        check("mid_rst_vld", bus.OUT_VLD, 0);
        check("mid_rst_count", bus.COUNT, 0);
        cycle(1'b1, 16'h1234, 1'b1, 1'b1);
        cycle(1'b1, 16'h5678, 1'b1, 1'b1);
        base = npop;
        k = 0;
        while (npop == base && k < 20) begin
            cycle(1'b0, '0, 1'b1, 1'b1);
            k++;
        end
        check("first_after_rst", last_pop, 16'h1234);
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
